// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencing controller for one radix-2 SDF FFT stage.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     input sample present
//   in_last      final sample of the final frame (qualified by in_valid)
//   in_ready     input accepted this cycle (low only while draining)
//   shift_en     delay line / datapath advance on this edge
//   bf_sel       1 = butterfly, 0 = pass input into delay line
//   out_sel      1 = output is butterfly sum, 0 = delay-line head
//   drain        feed zero into the delay line
//   tw_addr      twiddle ROM address for the current output
//   tw_en        twiddle multiply applies to the current output
//   out_valid    datapath output valid
//   frame_done   pulse on the last output of each frame
//   err          pulse on a misplaced in_last
module sdf_stage_ctrl #(
   parameter int N_HALF     = 64,
   parameter int LOG_N_HALF = 6,
   parameter int TW_AW      = 8,
   parameter int TW_STRIDE  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             shift_en,
   output logic             bf_sel,
   output logic             out_sel,
   output logic             drain,
   output logic [TW_AW-1:0] tw_addr,
   output logic             tw_en,
   output logic             out_valid,
   output logic             frame_done,
   output logic             err
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   localparam logic [LOG_N_HALF:0] HALF    = (LOG_N_HALF+1)'(N_HALF);
   localparam logic [LOG_N_HALF:0] HALF_M1 = (LOG_N_HALF+1)'(N_HALF-1);
   localparam logic [LOG_N_HALF:0] CNT_END = '1;
   state_t                state, state_nxt;
   logic [LOG_N_HALF:0]   cnt, cnt_nxt;
   logic                  primed, primed_nxt;
   logic                  acc, step, at_hm1, last_ok;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         primed <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         primed <= primed_nxt;
      end
   always_comb begin
      in_ready   = state != DRAIN;
      // gating with rst keeps every output quiet while reset is held
      acc        = !rst && in_valid && in_ready;
      step       = acc || state == DRAIN;
      at_hm1     = cnt == HALF_M1;
      last_ok    = state == RUN && cnt == CNT_END;
      shift_en   = step;
      bf_sel     = step && cnt[LOG_N_HALF];
      out_sel    = cnt[LOG_N_HALF];
      drain      = state == DRAIN;
      out_valid  = step && (primed || cnt == HALF) && state != IDLE;
      tw_en      = out_valid && !cnt[LOG_N_HALF];
      tw_addr    = tw_en ? TW_AW'(cnt[LOG_N_HALF-1:0] * TW_STRIDE) : '0;
      frame_done = out_valid && at_hm1;
      err        = acc && in_last && !last_ok;
      state_nxt  = state;
      cnt_nxt    = step ? cnt + 1'b1 : cnt;
      primed_nxt = primed || (step && at_hm1);
      if (state == IDLE && acc)
         state_nxt = RUN;
      if (acc && in_last && last_ok)
         state_nxt = DRAIN;
      if (state == DRAIN && at_hm1) begin
         state_nxt  = IDLE;
         cnt_nxt    = '0;
         primed_nxt = 1'b0;
      end
   end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: randomized bench for sdf_stage_ctrl against a sample-index model.
module tb_sdf_stage_ctrl;
   localparam int N  = 64;
   localparam int LG = 6;
   localparam int AW = 8;
   localparam int S  = 4;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready, shift_en, bf_sel, out_sel, drain, tw_en, out_valid, frame_done, err;
   logic [AW-1:0] tw_addr;
   int vectors = 0, miscompares = 0;
   int i_m = 0, d_m = 0;
   bit dr_m = 1'b0;
   int n_ov = 0, n_fd = 0, n_err = 0, first_ov = -1, acc_rst = 0, last_tw = -1;

   sdf_stage_ctrl #(.N_HALF(N), .LOG_N_HALF(LG), .TW_AW(AW), .TW_STRIDE(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .shift_en(shift_en), .bf_sel(bf_sel), .out_sel(out_sel), .drain(drain),
      .tw_addr(tw_addr), .tw_en(tw_en), .out_valid(out_valid),
      .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: i_m = samples accepted since idle, p = position within the frame;
   // outputs follow from whether the sample index has passed the delay depth.
   always @(negedge clk) begin
      bit acc, ov, rdy;
      int p;
      if (rst) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_shift_en", shift_en, 0);
         chk("rst_bf_sel", bf_sel, 0);
         chk("rst_out_sel", out_sel, 0);
         chk("rst_drain", drain, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_tw_en", tw_en, 0);
         chk("rst_tw_addr", tw_addr, 0);
         chk("rst_frame_done", frame_done, 0);
         chk("rst_err", err, 0);
         i_m = 0; dr_m = 0; d_m = 0; first_ov = -1; acc_rst = 0;
      end else begin
         rdy = !dr_m;
         acc = in_valid && rdy;
         p   = dr_m ? d_m : i_m % (2*N);
         ov  = dr_m || (acc && i_m >= N);
         chk("in_ready", in_ready, rdy);
         chk("shift_en", shift_en, acc || dr_m);
         chk("bf_sel", bf_sel, acc && p >= N);
         chk("out_sel", out_sel, p >= N);
         chk("drain", drain, dr_m);
         chk("out_valid", out_valid, ov);
         chk("tw_en", tw_en, ov && p < N);
         chk("tw_addr", tw_addr, (ov && p < N) ? (p*S) % (1 << AW) : 0);
         chk("frame_done", frame_done, ov && p == N-1);
         chk("err", err, acc && in_last && p != 2*N-1);
         if (out_valid) begin
            n_ov++;
            if (first_ov < 0) first_ov = acc_rst;
         end
         if (frame_done) n_fd++;
         if (frame_done && drain) last_tw = tw_addr;
         if (err) n_err++;
         if (acc) acc_rst++;
         if (dr_m) begin
            d_m++;
            if (d_m == N) begin dr_m = 0; i_m = 0; end
         end else if (acc) begin
            if (in_last && p == 2*N-1) begin dr_m = 1; d_m = 0; end
            else i_m++;
         end
      end
   end

   task automatic send(input int n, input int bad, input int gap, input bit cut);
      int k = 0;
      while (k < n) begin
         @(posedge clk); #1;
         if (int'($urandom_range(99)) < gap) begin
            in_valid = 0; in_last = $urandom_range(1);
         end else begin
            k++;
            in_valid = 1;
            in_last  = (k == n && !cut) || k == bad;
         end
      end
      @(posedge clk); #1;
      in_valid = 0; in_last = 0;
      if (!cut) begin
         repeat (N) begin
            in_valid = $urandom_range(1); in_last = $urandom_range(1);
            @(posedge clk); #1;
         end
         in_valid = 0; in_last = 0;
         repeat (3) @(posedge clk);
         #1;
      end
   endtask

   task automatic scen(input string nm, input int n, input int bad, input int gap,
                       input int efd, input int eerr);
      int b_ov = n_ov, b_fd = n_fd, b_err = n_err;
      send(n, bad, gap, 1'b0);
      chk({nm, "_outputs"}, n_ov - b_ov, n);
      chk({nm, "_frame_done"}, n_fd - b_fd, efd);
      chk({nm, "_err"}, n_err - b_err, eerr);
   endtask

   initial begin
      int fd0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      scen("one_frame", 128, 0, 0, 1, 0);
      chk("first_ov_index", first_ov, 64);
      chk("last_drain_tw", last_tw, 252);
      scen("two_frames", 256, 0, 0, 2, 0);
      scen("gaps", 128, 0, 30, 1, 0);
      scen("bad_last", 128, 50, 0, 1, 1);
      fd0 = n_fd;
      send(90, 0, 0, 1'b1);
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("cut_no_frame_done", n_fd - fd0, 0);
      scen("after_reset", 128, 0, 0, 1, 0);
      chk("after_reset_first_ov", first_ov, 64);
      scen("idle_last", 128, 1, 20, 1, 1);
      for (int r = 0; r < 4; r++) begin
         int f = $urandom_range(1, 3);
         scen("random", 128*f, 0, $urandom_range(40), f, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
- Sequencing controller for one radix-2 single-path delay-feedback (SDF) FFT stage built around a 64-deep complex shift register.
- Generates the delay-line shift enable, butterfly/pass select, output-path select, twiddle ROM address and output framing from the input sample stream.
- Runs an autonomous drain after the last frame so the delay line empties without extra input samples.
- One instance per stage; N_HALF sets the stage's delay depth.

Parameters:
- N_HALF, 64, delay-line depth in samples; power of two, >= 2. One frame is 2*N_HALF samples.
- LOG_N_HALF, 6, log2(N_HALF).
- TW_AW, 8, twiddle ROM address width.
- TW_STRIDE, 1, twiddle address increment per sample (2^k for later stages).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input sample present this cycle.
- in_last  in  1  qualifies the final input sample of the final frame; valid only with in_valid.
- in_ready  out  1  controller accepts input this cycle.
- shift_en  out  1  delay line and datapath registers advance on this edge.
- bf_sel  out  1  1 = butterfly (sum to output, difference to delay line); 0 = pass input into delay line.
- out_sel  out  1  1 = output is butterfly sum; 0 = output is delay-line head (difference).
- drain  out  1  datapath must feed zero into the delay line.
- tw_addr  out  TW_AW  twiddle ROM address for the current output.
- tw_en  out  1  twiddle multiply applies to the current output.
- out_valid  out  1  datapath output is valid this cycle.
- frame_done  out  1  one-cycle pulse on the last output of each frame.
- err  out  1  one-cycle pulse on a misplaced in_last.

Behaviour:
- State: FSM {IDLE, RUN, DRAIN}; cnt is LOG_N_HALF+1 bits and wraps modulo 2*N_HALF; primed is 1 bit.
- Reset (async, rst=1): state=IDLE, cnt=0, primed=0. Every output reads 0 except in_ready=1.
- in_ready = (state != DRAIN).
- step = (in_valid && in_ready) || (state == DRAIN). shift_en = step. cnt increments on step only; no step means all state holds (stall allowed anywhere in IDLE/RUN).
- All outputs except in_ready are combinational from registered state, cnt, primed and the current step. They are aligned to the cycle of the step so the datapath captures on the same edge.
- bf_sel = step && cnt[LOG_N_HALF]. out_sel = cnt[LOG_N_HALF]. drain = (state == DRAIN).
- primed is set on a step with cnt == N_HALF-1, and cleared on entering IDLE.
- out_valid = step && (primed || cnt == N_HALF) && state != IDLE. Output latency is exactly N_HALF steps; the total number of outputs equals the total number of inputs.
- tw_en = out_valid && !cnt[LOG_N_HALF].
- tw_addr = (cnt[LOG_N_HALF-1:0] * TW_STRIDE) truncated to TW_AW bits when tw_en is 1, else 0.
- frame_done = out_valid && cnt == N_HALF-1.
- IDLE: the first accepted sample (at cnt 0) steps and moves to RUN.
- RUN: in_last accepted with cnt == 2*N_HALF-1 moves to DRAIN (cnt wraps to 0).
- in_last accepted at any other cnt: err pulses, in_last is ignored, stay in RUN.
- in_last arriving in IDLE is also misplaced: err pulses and the FSM moves to RUN as normal.
- DRAIN: steps every cycle for N_HALF cycles (cnt 0..N_HALF-1) with out_valid=1. At cnt == N_HALF-1 frame_done pulses; the next state is IDLE with cnt=0 and primed=0.
- in_valid during DRAIN is ignored (in_ready=0).
- Back-to-back frames: no gap. cnt wraps 2*N_HALF-1 -> 0 and the FSM stays in RUN.
- Reset mid-frame or mid-drain: immediate return to reset values. Partial frames are discarded; no frame_done is issued.

Test Plan:
- Reset then one frame (N_HALF=64): 128 contiguous in_valid, in_last on the 128th -> first out_valid at step 64; outputs 64..127 have out_sel=1 and bf_sel=1; 64 drain cycles follow with tw_addr 0..63; frame_done once; 128 out_valid total; back to IDLE.
- Two back-to-back frames, in_last on sample 256 -> frame_done pulses at output indices 127 and 255; in_ready stays 1 until sample 256; no gap at the wrap.
- Random in_valid gaps (~30% idle) -> cnt, bf_sel and out_valid sequence identical to the gapless case once idle cycles are removed; shift_en=0 on every idle cycle.
- in_last on sample 50 -> err one-cycle pulse, FSM stays in RUN, frame completes normally on a correct in_last at sample 128.
- rst asserted at step 90 of frame 1 -> all outputs 0 and in_ready=1 asynchronously; a following full frame behaves as in the first scenario.
- TW_STRIDE=4, TW_AW=8 -> tw_addr steps 0,4,...,252 during difference outputs; tw_addr=0 when tw_en=0.
